prog_loader: RTL and testbench

- Byte-stream program loader directly upstream of the Octa16 core.
- Accepts a framed program image over a valid/ready byte interface: length header, payload bytes, checksum byte.
- Writes the payload into the core's instruction memory through the core's external write port (Ext_MemWrite / Ext_DataAdr / Ext_WriteData).
- Holds the core in reset until a frame loads with a matching checksum, then releases it.

---
 rtl/prog_loader.sv | 132 +++++++++++++
 tb/tb_prog_loader.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - framed byte-stream loader for the Octa16 instruction memory
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module prog_loader #(
  parameter logic [7:0] BASE_ADR       = 8'h00,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  input  logic       reload,
  output logic       ext_mem_write,
  output logic [7:0] ext_data_adr,
  output logic [7:0] ext_write_data,
  output logic       core_reset,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [1:0] HDR  = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] CSUM = 2'd2;
  localparam logic [1:0] RUN  = 2'd3;

  // A zero or negative budget would abort every frame immediately.
  if (TIMEOUT_CYCLES < 1) begin : gTimeoutRange
    $error("prog_loader: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0] state;
  logic [8:0] remaining;  // 9 bits so a zero header can stand for 256
  logic [7:0] index;
  logic [7:0] sum;
  logic       xfer;

  assign xfer = in_valid && in_ready;

`ifdef LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmoCnt;
  logic             tmoHit;
  assign tmoHit = (tmoCnt == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= HDR;
      remaining      <= 9'd0;
      index          <= 8'd0;
      sum            <= 8'd0;
      in_ready       <= 1'b0;
      ext_mem_write  <= 1'b0;
      ext_data_adr   <= 8'd0;
      ext_write_data <= 8'd0;
      core_reset     <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      err            <= 1'b0;
`ifdef LOADER_TIMEOUT_EN
      tmoCnt         <= '0;
`endif
    end else begin
      ext_mem_write <= 1'b0;
      in_ready      <= (state != RUN);
      case (state)
        HDR: begin
          if (xfer) begin
            remaining <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            index     <= 8'd0;
            sum       <= 8'd0;
            err       <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b1;
            state     <= LOAD;
          end
        end
        LOAD: begin
          if (xfer) begin
            ext_mem_write  <= 1'b1;
            ext_data_adr   <= BASE_ADR + index;
            ext_write_data <= in_data;
            index          <= index + 8'd1;
            sum            <= sum + in_data;
            remaining      <= remaining - 9'd1;
            if (remaining == 9'd1) state <= CSUM;
          end
        end
        CSUM: begin
          if (xfer) begin
            busy <= 1'b0;
            if (in_data == sum) begin
              state      <= RUN;
              core_reset <= 1'b0;
              done       <= 1'b1;
              in_ready   <= 1'b0;
            end else begin
              state <= HDR;
              err   <= 1'b1;
            end
          end
        end
        default: begin
          if (reload) begin
            state      <= HDR;
            core_reset <= 1'b1;
            done       <= 1'b0;
            in_ready   <= 1'b1;
          end
        end
      endcase
`ifdef LOADER_TIMEOUT_EN
      if (state == LOAD || state == CSUM) begin
        if (xfer) begin
          tmoCnt <= '0;
        end else if (tmoHit) begin
          tmoCnt <= '0;
          state  <= HDR;
          err    <= 1'b1;
          busy   <= 1'b0;
        end else begin
          tmoCnt <= tmoCnt + 1'b1;
        end
      end else if (state == HDR && xfer) begin
        tmoCnt <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed scoreboard bench for prog_loader
// Two instances (base 00 and base 80) receive the same stream.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       inValid;
  logic [7:0] inData;
  logic       reload;

  logic       inReadyA, memWriteA, coreResetA, busyA, doneA, errA;
  logic [7:0] adrA, dataA;
  logic       inReadyB, memWriteB, coreResetB, busyB, doneB, errB;
  logic [7:0] adrB, dataB;

  int errors = 0;
  int checks = 0;
  int writesA = 0;
  logic [7:0] payIdx;
  logic [15:0] qA[$];
  logic [15:0] qB[$];
  logic [7:0] frameBytes[$];

  always #5 clk = ~clk;

  prog_loader #(.BASE_ADR(8'h00), .TIMEOUT_CYCLES(16)) dutA (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_data(inData), .in_ready(inReadyA),
    .reload(reload), .ext_mem_write(memWriteA), .ext_data_adr(adrA), .ext_write_data(dataA),
    .core_reset(coreResetA), .busy(busyA), .done(doneA), .err(errA)
  );

  prog_loader #(.BASE_ADR(8'h80), .TIMEOUT_CYCLES(16)) dutB (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_data(inData), .in_ready(inReadyB),
    .reload(reload), .ext_mem_write(memWriteB), .ext_data_adr(adrB), .ext_write_data(dataB),
    .core_reset(coreResetB), .busy(busyB), .done(doneB), .err(errB)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (memWriteA === 1'b1) begin
      writesA++;
      chk("write_a_expected", 32'(qA.size() != 0), 32'd1);
      if (qA.size() != 0) begin
        e = qA.pop_front();
        chk("write_a_adr_data", {16'd0, adrA, dataA}, {16'd0, e});
      end
    end
    if (memWriteB === 1'b1) begin
      chk("write_b_expected", 32'(qB.size() != 0), 32'd1);
      if (qB.size() != 0) begin
        e = qB.pop_front();
        chk("write_b_adr_data", {16'd0, adrB, dataB}, {16'd0, e});
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the byte is accepted.
  task automatic sendByte(input logic [7:0] b, input bit payload, input int gap);
    int n = 0;
    if (payload) begin
      qA.push_back({payIdx, b});
      qB.push_back({payIdx + 8'h80, b});
    end
    inValid = 1'b1;
    inData  = b;
    while (inReadyA !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("in_ready_wait", 32'(inReadyA), 32'd1);
    @(negedge clk);
    if (payload) begin
      chk("write_latency", {31'd0, memWriteA}, 32'd1);
      payIdx = payIdx + 8'd1;
    end
    if (gap > 0) begin
      inValid = 1'b0;
      @(negedge clk);
      if (payload) chk("single_cycle_write", {31'd0, memWriteA}, 32'd0);
      repeat (gap - 1) @(negedge clk);
    end
  endtask

  task automatic sendFrame(input logic [7:0] hdr, input logic [7:0] csum, input int gap);
    payIdx  = 8'd0;
    writesA = 0;
    sendByte(hdr, 1'b0, gap);
    foreach (frameBytes[i]) sendByte(frameBytes[i], 1'b1, gap);
    sendByte(csum, 1'b0, 0);
    inValid = 1'b0;
  endtask

  task automatic pulseReload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_core_reset", {31'd0, coreResetA}, 32'd1);
    chk("reload_done", {31'd0, doneA}, 32'd0);
    @(negedge clk);
    chk("reload_in_ready", {31'd0, inReadyA}, 32'd1);
  endtask

  // {in_ready, mem_write, adr, data, core_reset, busy, done, err}
  function automatic logic [31:0] snapA();
    return {12'd0, inReadyA, memWriteA, adrA, dataA, coreResetA, busyA, doneA, errA};
  endfunction

  initial begin
    reset = 1'b1; inValid = 1'b0; inData = 8'h00; reload = 1'b0; payIdx = 8'd0;
    repeat (2) @(negedge clk);
    chk("reset_values", snapA(), {12'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    reset = 1'b0;
    @(negedge clk);
    chk("hdr_in_ready", {31'd0, inReadyA}, 32'd1);

    // Basic load
    frameBytes = '{8'hAA, 8'hBB, 8'hCC};
    sendFrame(8'h03, 8'h31, 0);
    chk("basic_run", {28'd0, coreResetA, busyA, doneA, inReadyA}, {28'd0, 4'b0010});
    chk("basic_writes", 32'(writesA), 32'd3);

    // in_valid ignored while running
    inValid = 1'b1; inData = 8'h55;
    repeat (4) @(negedge clk);
    inValid = 1'b0;
    chk("run_ignores_input", {29'(writesA), doneA, coreResetA, busyA}, {29'd3, 3'b100});
    pulseReload();

    // Bad checksum, then good frame
    frameBytes = '{8'h10, 8'h20};
    sendFrame(8'h02, 8'h31, 0);
    chk("bad_csum_state", {28'd0, errA, coreResetA, busyA, doneA}, {28'd0, 4'b1100});
    chk("bad_csum_writes", 32'(writesA), 32'd2);
    @(negedge clk);
    payIdx = 8'd0; writesA = 0;
    inValid = 1'b1;
    sendByte(8'h01, 1'b0, 0);
    chk("hdr_clears_err", {30'd0, errA, busyA}, {30'd0, 2'b01});
    sendByte(8'h05, 1'b1, 0);
    sendByte(8'h05, 1'b0, 0);
    inValid = 1'b0;
    chk("good_after_bad", {29'd0, doneA, coreResetA, errA}, {29'd0, 3'b100});
    pulseReload();

    // Length zero: 256 payload bytes, wraps address on the base-80 instance
    frameBytes.delete();
    for (int i = 0; i < 256; i++) frameBytes.push_back(8'h01);
    sendFrame(8'h00, 8'h00, 0);
    chk("len0_writes", 32'(writesA), 32'd256);
    chk("len0_done_b", {30'd0, doneB, coreResetB}, {30'd0, 2'b10});
    pulseReload();

    // Throttled input
    frameBytes = '{8'h0F, 8'hF0};
    sendFrame(8'h02, 8'hFF, 3);
    chk("throttle_writes", 32'(writesA), 32'd2);
    chk("throttle_done", {31'd0, doneA}, 32'd1);
    pulseReload();

    // Reset on the cycle the second payload byte is accepted
    payIdx = 8'd0; writesA = 0;
    sendByte(8'h04, 1'b0, 0);
    sendByte(8'h11, 1'b1, 0);
    inData = 8'h22; reset = 1'b1;
    @(negedge clk);
    chk("midload_reset_values", snapA(), {12'd0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0});
    reset = 1'b0; inValid = 1'b0;
    @(negedge clk);
    chk("midload_writes", 32'(writesA), 32'd1);

    // Stall after a header
    payIdx = 8'd0;
    sendByte(8'h04, 1'b0, 0);
    inValid = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    repeat (15) @(negedge clk);
    chk("timeout_not_yet", {31'd0, busyA}, 32'd1);
    @(negedge clk);
    chk("timeout_abort", {28'd0, errA, busyA, coreResetA, doneA}, {28'd0, 4'b1010});
`else
    repeat (40) @(negedge clk);
    chk("no_timeout_wait", {30'd0, busyA, errA}, {30'd0, 2'b10});
`endif
    chk("queue_a_empty", 32'(qA.size()), 32'd0);
    chk("queue_b_empty", 32'(qB.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
